// File: rtl/fir_coeff_pair_loader_if.sv
// fir_coeff_pair_loader_if: register-word input, frame sync and active coefficient outputs of the loader
// FIR_COEF_LOAD_COUNT_EN adds the load_count signal.
interface fir_coeff_pair_loader_if #(
    parameter int COEF_W = 16
);
    logic [2*COEF_W-1:0] reg_data;
    logic                sync_in;
    logic [COEF_W-1:0]   coef_b16;
    logic [COEF_W-1:0]   coef_b17;
    logic                coef_update;
    logic                pending;
`ifdef FIR_COEF_LOAD_COUNT_EN
    logic [15:0]         load_count;
    modport master (output reg_data, sync_in, input coef_b16, coef_b17, coef_update, pending, load_count);
    modport slave  (input reg_data, sync_in, output coef_b16, coef_b17, coef_update, pending, load_count);
`else
    modport master (output reg_data, sync_in, input coef_b16, coef_b17, coef_update, pending);
    modport slave  (input reg_data, sync_in, output coef_b16, coef_b17, coef_update, pending);
`endif
endinterface

// File: rtl/fir_coeff_pair_loader.sv
// fir_coeff_pair_loader: debounces the b16/b17 coefficient word and applies it only on frame sync
// FIR_COEF_LOAD_COUNT_EN adds a wrapping count of applies on bus.load_count.
module fir_coeff_pair_loader #(
    parameter int                COEF_W        = 16,
    parameter int                STABLE_CYCLES = 4,
    parameter logic [COEF_W-1:0] RESET_B16     = '0,
    parameter logic [COEF_W-1:0] RESET_B17     = '0
) (
    input logic                  user_clk,
    input logic                  user_rst,
    fir_coeff_pair_loader_if.slave bus
);
    localparam int W  = 2 * COEF_W;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [W-1:0] RESET_PAIR = {RESET_B16, RESET_B17};
    typedef enum logic {IDLE, SETTLE} state_t;
    state_t        state, state_d;
    logic [W-1:0]  reg_q, acc, cand, cand_d, shadow;
    logic [CW-1:0] cnt, cnt_d;
    logic          wr, apply, pending;
    always_ff @(posedge user_clk) begin
        if (user_rst) state <= IDLE;
        else          state <= state_d;
    end
    // cnt >= covers STABLE_CYCLES=1, where the first matching SETTLE cycle writes
    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        wr      = 1'b0;
        if (state == IDLE) begin
            if (reg_q != acc) begin
                state_d = SETTLE;
                cand_d  = reg_q;
                cnt_d   = CW'(1);
            end
        end else if (reg_q == acc) begin
            state_d = IDLE;
        end else if (reg_q != cand) begin
            cand_d = reg_q;
            cnt_d  = CW'(1);
        end else if (cnt >= CW'(STABLE_CYCLES - 1)) begin
            wr      = 1'b1;
            state_d = IDLE;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end
    assign apply       = bus.sync_in & pending;
    assign bus.pending = pending;
    // a write on the apply edge keeps pending so the fresh pair waits for the next sync
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            reg_q           <= '0;
            acc             <= RESET_PAIR;
            cand            <= '0;
            cnt             <= '0;
            shadow          <= RESET_PAIR;
            pending         <= 1'b0;
            bus.coef_b16    <= RESET_B16;
            bus.coef_b17    <= RESET_B17;
            bus.coef_update <= 1'b0;
        end else begin
            reg_q           <= bus.reg_data;
            cand            <= cand_d;
            cnt             <= cnt_d;
            acc             <= wr ? cand : acc;
            shadow          <= wr ? cand : shadow;
            pending         <= wr | (pending & ~bus.sync_in);
            bus.coef_b16    <= apply ? shadow[W-1:COEF_W] : bus.coef_b16;
            bus.coef_b17    <= apply ? shadow[COEF_W-1:0] : bus.coef_b17;
            bus.coef_update <= apply;
        end
    end
`ifdef FIR_COEF_LOAD_COUNT_EN
    always_ff @(posedge user_clk) begin
        if (user_rst) bus.load_count <= '0;
        else          bus.load_count <= bus.load_count + {15'd0, apply};
    end
`endif
endmodule
